// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci stream generator.
//   FIB_W_DEF   : default width of a Fibonacci term
//   fib_state_e : generator FSM state encoding
package fib_pkg;

    localparam int FIB_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fib_state_e;

endpackage

// File: rtl/fib_adder.sv
// W-bit adder with carry-out, used to form the next Fibonacci term.
// Purely combinational.
//   a, b  : addends
//   sum   : (a + b) mod 2^W
//   carry : carry-out of the W-bit addition
module fib_adder
    import fib_pkg::*;
#(
    parameter int W = FIB_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/fib_stream_gen.sv
// Fibonacci stream generator with a valid/ready output handshake.
// A run is requested with start + n_terms while idle; terms are emitted one
// per accepted handshake, the final one flagged with term_last, then done
// pulses for one cycle.
//   clk, rst       : clock, synchronous active-high reset
//   start, n_terms : run request and number of terms (1..F valid)
//   busy           : run in progress
//   term_valid/term_ready/term_data/term_idx/term_last : output stream
//   ovf            : sticky, a computed term overflowed W bits
//   done           : one-cycle end-of-run pulse
// Compile option FIB_OVF_STOP_EN: when defined, an overflow ends the run
// after the last non-overflowed term instead of wrapping.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | emitting terms, a/b advance on each handshake
// DRAIN | overflow seen, emitting the final valid term without updating b
// DONE  | one-cycle done pulse, back to IDLE
module fib_stream_gen
    import fib_pkg::*;
#(
    parameter int           W     = FIB_W_DEF,
    parameter logic [W-1:0] Seed1 = '0,
    parameter logic [W-1:0] Seed2 = W'(1),
    parameter int           F     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [$clog2(F+1)-1:0] n_terms,
    output logic                   busy,
    output logic                   term_valid,
    input  logic                   term_ready,
    output logic [W-1:0]           term_data,
    output logic [$clog2(F)-1:0]   term_idx,
    output logic                   term_last,
    output logic                   ovf,
    output logic                   done
);

    localparam int             CW    = $clog2(F + 1);
    localparam int             IW    = $clog2(F);
    localparam logic [CW-1:0]  F_CNT = CW'(F);
    localparam logic [CW:0]    TWO   = 2;

    fib_state_e    state_q, state_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] n_q, n_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  sum;
    logic          carry;
    logic [CW-1:0] idx_ext;
    logic [CW-1:0] n_last;
    logic [CW:0]   sum_idx;
    logic          sum_in_run;

    fib_adder #(.W(W)) u_adder (
        .a     (a_q),
        .b     (b_q),
        .sum   (sum),
        .carry (carry)
    );

    // a+b produces term idx+2; its overflow only matters if that term
    // would actually be emitted in this run.
    always_comb begin
        idx_ext    = CW'(idx_q);
        n_last     = n_q - CW'(1);
        sum_idx    = {1'b0, idx_ext} + TWO;
        sum_in_run = (sum_idx < {1'b0, n_q});
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        n_d        = n_q;
        ovf_d      = ovf_q;
        busy       = 1'b0;
        term_valid = 1'b0;
        term_last  = 1'b0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if ((n_terms != '0) && (n_terms <= F_CNT)) begin
                        state_d = RUN;
                        n_d     = n_terms;
                        a_d     = Seed1;
                        b_d     = Seed2;
                        idx_d   = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                busy       = 1'b1;
                term_valid = 1'b1;
                term_last  = (idx_ext == n_last);
                if (term_ready) begin
                    a_d   = b_q;
                    b_d   = sum;
                    idx_d = idx_q + IW'(1);
                    if (term_last) begin
                        state_d = DONE;
                    end else if (carry && sum_in_run) begin
                        ovf_d = 1'b1;
`ifdef FIB_OVF_STOP_EN
                        state_d = DRAIN;
`endif
                    end
                end
            end
            DRAIN: begin
                // Only the term already held in a is still good.
                busy       = 1'b1;
                term_valid = 1'b1;
                term_last  = 1'b1;
                if (term_ready) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
        end
    end

    // Data/index read as zero whenever no term is being offered.
    assign term_data = term_valid ? a_q : '0;
    assign term_idx  = term_valid ? idx_q : '0;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fib_stream_gen.sv
// Testbench for fib_stream_gen: one default instance (W=32, F=10) and one
// narrow instance (W=8, F=16) for overflow behaviour. Expected terms come
// from a bench-side Fibonacci model pushed into per-instance queues at start.
module tb_fib_stream_gen;

    typedef struct {
        logic [31:0] d;
        int          idx;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_start, a_ready, a_busy, a_valid, a_last, a_ovf, a_done;
    logic [3:0]  a_n;
    logic [31:0] a_data;
    logic [3:0]  a_idx;

    logic        b_start, b_ready, b_busy, b_valid, b_last, b_ovf, b_done;
    logic [4:0]  b_n;
    logic [7:0]  b_data;
    logic [3:0]  b_idx;

    exp_t        qa[$];
    exp_t        qb[$];
    int          checks = 0;
    int          failures = 0;
    int          done_a = 0;
    int          done_b = 0;
    int          hs_b = 0;
    logic [7:0]  obs_b [0:15];
    bit          exp_ovf_b;

    fib_stream_gen u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .n_terms(a_n), .busy(a_busy),
        .term_valid(a_valid), .term_ready(a_ready), .term_data(a_data),
        .term_idx(a_idx), .term_last(a_last), .ovf(a_ovf), .done(a_done)
    );

    fib_stream_gen #(.W(8), .F(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .n_terms(b_n), .busy(b_busy),
        .term_valid(b_valid), .term_ready(b_ready), .term_data(b_data),
        .term_idx(b_idx), .term_last(b_last), .ovf(b_ovf), .done(b_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fibonacci reference for one run, width 32 (instance a) or 8 (instance b).
    task automatic model_run(input bit is_b, input int n);
        logic [32:0] s;
        logic [31:0] x, y, msk;
        int          w, fmax, stop;
        exp_t        e;
        w    = is_b ? 8 : 32;
        fmax = is_b ? 16 : 10;
        msk  = is_b ? 32'h0000_00FF : 32'hFFFF_FFFF;
        x    = 32'd0;
        y    = 32'd1;
        stop = -1;
        if (n >= 1 && n <= fmax) begin
            if (is_b) exp_ovf_b = 1'b0;
            for (int i = 0; i < n; i++) begin
                e.d    = x;
                e.idx  = i;
                e.last = (i == n - 1) || (i == stop);
                if (is_b) qb.push_back(e); else qa.push_back(e);
                if (e.last) break;
                s = {1'b0, x} + {1'b0, y};
                if (s[w] && (i + 2 < n)) begin
                    if (is_b) exp_ovf_b = 1'b1;
`ifdef FIB_OVF_STOP_EN
                    stop = i + 1;
`endif
                end
                x = y;
                y = s[31:0] & msk;
            end
        end
    endtask

    // Check handshakes against the scoreboard, then advance one clock.
    task automatic cyc();
        exp_t e;
        if (a_valid && a_ready) begin
            chk("a_term_expected", qa.size() > 0, 1'b1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_data", a_data, e.d);
                chk("a_idx", a_idx, e.idx);
                chk("a_last", a_last, e.last);
            end
        end
        if (a_done) done_a++;
        if (b_valid && b_ready) begin
            chk("b_term_expected", qb.size() > 0, 1'b1);
            obs_b[b_idx] = b_data;
            hs_b++;
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_data", b_data, e.d);
                chk("b_idx", b_idx, e.idx);
                chk("b_last", b_last, e.last);
            end
        end
        if (b_done) done_b++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_a(input int n);
        model_run(1'b0, n);
        a_n     = 4'(n);
        a_start = 1'b1;
        cyc();
        a_start = 1'b0;
    endtask

    task automatic start_b(input int n);
        model_run(1'b1, n);
        hs_b    = 0;
        b_n     = 5'(n);
        b_start = 1'b1;
        cyc();
        b_start = 1'b0;
    endtask

    task automatic wait_done(input bit is_b, input int budget, input int exp_k,
                             input bit toggle, input string tag);
        int d0;
        int k;
        d0 = is_b ? done_b : done_a;
        k  = 0;
        while (((is_b ? done_b : done_a) == d0) && (k < budget)) begin
            if (toggle) a_ready = (k % 2 == 0);
            cyc();
            k++;
        end
        a_ready = 1'b1;
        chk({tag, "_cycles"}, k, exp_k);
        cyc();
        chk({tag, "_done_once"}, (is_b ? done_b : done_a) - d0, 1);
        chk({tag, "_queue_empty"}, is_b ? qb.size() : qa.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_busy"}, a_busy, 1'b0);
        chk({tag, "_a_valid"}, a_valid, 1'b0);
        chk({tag, "_a_data"}, a_data, 32'd0);
        chk({tag, "_a_idx"}, a_idx, 4'd0);
        chk({tag, "_a_last"}, a_last, 1'b0);
        chk({tag, "_a_ovf"}, a_ovf, 1'b0);
        chk({tag, "_a_done"}, a_done, 1'b0);
        chk({tag, "_b_busy"}, b_busy, 1'b0);
        chk({tag, "_b_valid"}, b_valid, 1'b0);
        chk({tag, "_b_data"}, b_data, 8'd0);
        chk({tag, "_b_ovf"}, b_ovf, 1'b0);
        chk({tag, "_b_done"}, b_done, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_start = 1'b0; a_n = '0; a_ready = 1'b1;
        b_start = 1'b0; b_n = '0; b_ready = 1'b1;
        exp_ovf_b = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        cyc();

        // Full-throughput run of 10 terms.
        start_a(10);
        chk("a_latency", a_valid, 1'b1);
        wait_done(1'b0, 40, 11, 1'b0, "a_run10");
        chk("a_run10_ovf", a_ovf, 1'b0);

        // Back-pressure: ready toggles 1,0,1,0,...
        start_a(5);
        wait_done(1'b0, 40, 10, 1'b1, "a_stall5");

        // start held during RUN with a different count is ignored.
        start_a(4);
        a_start = 1'b1;
        a_n     = 4'd2;
        cyc();
        cyc();
        a_start = 1'b0;
        wait_done(1'b0, 40, 3, 1'b0, "a_start_ignored");

        // Out-of-range counts: no terms, done the next cycle.
        start_a(0);
        chk("a_n0_valid", a_valid, 1'b0);
        chk("a_n0_done", a_done, 1'b1);
        wait_done(1'b0, 10, 1, 1'b0, "a_n0");
        start_a(11);
        chk("a_n11_valid", a_valid, 1'b0);
        wait_done(1'b0, 10, 1, 1'b0, "a_n11");

        // Reset in the middle of a run at idx 4.
        start_a(10);
        repeat (4) cyc();
        chk("a_mid_idx", a_idx, 4'd4);
        a_ready = 1'b0;
        rst     = 1'b1;
        cyc();
        chk_reset_outputs("midreset");
        qa.delete();
        rst     = 1'b0;
        a_ready = 1'b1;
        start_a(3);
        wait_done(1'b0, 20, 4, 1'b0, "a_after_reset");

        // Narrow instance: overflow at term 14.
        start_b(16);
`ifdef FIB_OVF_STOP_EN
        wait_done(1'b1, 40, 15, 1'b0, "b_ovf_stop");
        chk("b_term_count", hs_b, 14);
`else
        wait_done(1'b1, 40, 17, 1'b0, "b_ovf_wrap");
        chk("b_term_count", hs_b, 16);
        chk("b_term14_wrap", obs_b[14], 8'd121);
`endif
        chk("b_term13", obs_b[13], 8'd233);
        chk("b_ovf_set", b_ovf, exp_ovf_b);
        chk("b_ovf_expected", exp_ovf_b, b_valid ^ 1'b1);

        // n_terms = F+1 rejected; ovf untouched because no run started.
        start_b(17);
        chk("b_n17_valid", b_valid, 1'b0);
        wait_done(1'b1, 10, 1, 1'b0, "b_n17");
        chk("b_n17_ovf_kept", b_ovf, 1'b1);

        // A fresh accepted run clears ovf.
        start_b(5);
        chk("b_ovf_cleared", b_ovf, 1'b0);
        wait_done(1'b1, 20, 6, 1'b0, "b_run5");
        chk("b_run5_ovf", b_ovf, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fib_stream_gen.md
FIB_STREAM_GEN -- requirements
Module: fib_stream_gen

Interface
REQ-001 SHALL have parameter W, default 32: width of every Fibonacci term.
REQ-002 SHALL have parameter Seed1, default 0: term 0.
REQ-003 SHALL have parameter Seed2, default 1: term 1.
REQ-004 SHALL have parameter F, default 10: maximum terms per run, F>=2.
REQ-005 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: run request, sampled only in IDLE.
REQ-008 SHALL have port n_terms, input, $clog2(F+1): terms to emit, latched on start accept.
REQ-009 SHALL have port busy, output, 1: high in RUN and DRAIN.
REQ-010 SHALL have port term_valid, output, 1: term_data is valid.
REQ-011 SHALL have port term_ready, input, 1: consumer accepts the term.
REQ-012 SHALL have port term_data, output, W: current Fibonacci term.
REQ-013 SHALL have port term_idx, output, $clog2(F): index of term_data.
REQ-014 SHALL have port term_last, output, 1: marks the final term of a run.
REQ-015 SHALL have port ovf, output, 1: sticky; a computed term exceeded W bits.
REQ-016 SHALL have port done, output, 1: one-cycle pulse after the last handshake.

Function
REQ-017 SHALL use an FSM with states IDLE, RUN, DRAIN and DONE.
REQ-018 IDLE->RUN: start=1 and n_terms in 1..F. Latch n_terms, load a=Seed1 and b=Seed2, set idx=0, clear ovf.
REQ-019 start with n_terms=0 or n_terms>F: go to DONE; emit no terms; done pulses the next cycle.
REQ-020 In RUN, term_valid=1, term_data=a and term_idx=idx. Outputs hold stable while term_ready=0.
REQ-021 Handshake on term_valid and term_ready both high. Next cycle: a<=b, b<=a+b (mod 2^W), idx<=idx+1. One term per cycle at full throughput.
REQ-022 term_last=1 when idx==latched n_terms-1. A handshake with term_last moves to DONE.
REQ-023 DRAIN is entered on overflow (see REQ-033). It is identical to RUN except that no further b update occurs.
REQ-024 DONE: term_valid=0 and done=1 for exactly one cycle, then IDLE.
REQ-025 ovf is set when the carry-out of a+b is 1 for a sum whose term index is below the latched count.
REQ-026 start asserted in RUN, DRAIN or DONE is ignored.
REQ-027 Latency is 1 cycle: first term_valid appears the cycle after start is accepted.
REQ-028 term_data for n_terms=1 SHALL be Seed1 only, with term_last=1.

Reset
REQ-029 rst=1 at any clock edge forces IDLE, including mid-run with a pending term. The in-flight term is discarded.
REQ-030 Reset values: busy=0, term_valid=0, term_data=0, term_idx=0, term_last=0, ovf=0, done=0.

Configuration
REQ-031 Macro FIB_OVF_STOP_EN SHALL be the only compile option.
REQ-032 Without the macro: overflow sets ovf only; terms wrap mod 2^W; the run completes all n_terms.
REQ-033 With the macro: on overflow the FSM enters DRAIN. It emits remaining already-valid terms up to and including the last non-overflowed term, which is flagged term_last=1, then goes to DONE.

Structure
REQ-034 Package fib_pkg SHALL hold the FSM state enum fib_state_e and the default-width constant FIB_W_DEF=32.
REQ-035 Sub-module fib_adder SHALL compute the W-bit sum plus carry-out. It is purely combinational and used once.

Verification
REQ-036 Default params, n_terms=10, term_ready=1 -> terms 0,1,1,2,3,5,8,13,21,34 on 10 consecutive cycles; term_last on idx 9; done one cycle later; ovf=0.
REQ-037 n_terms=5, term_ready toggling 1,0,1,0 -> each term held stable while ready=0; 5 handshakes total; values 0,1,1,2,3.
REQ-038 W=8, n_terms=F=16, macro off -> term 13 (233) is correct; term 14 wraps to 121 (377 mod 256); ovf=1 by the end.
REQ-039 W=8, n_terms=16, macro on -> last emitted term is 233 at idx 13 with term_last=1; done follows; ovf=1.
REQ-040 start with n_terms=0, then with n_terms=F+1 -> no term_valid; done pulses once for each.
REQ-041 rst asserted at idx 4 mid-run -> next cycle all outputs are at reset values; a new start with n_terms=3 yields 0,1,1.
